// File: rtl/adder_tree_pkg.sv
// Shared types and helpers for the adder-tree sequencer: controller states and
// the pass-count helper used to size the reduction loop.
package adder_tree_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REDUCE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Number of pairwise-halving passes needed to fold 2*num words into one.
    function automatic int passes_f(input int num);
        return $clog2(2 * num);
    endfunction

endpackage

// File: rtl/adder_tree_sequencer_if.sv
// Producer/consumer handshake bundle for the adder-tree sequencer.
// The master side drives operands and accepts results; the slave side is the sequencer.
interface adder_tree_sequencer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM        = 4
);
    logic                                in_valid;
    logic                                in_ready;
    logic [2*NUM-1:0][DATA_WIDTH-1:0]    in_data;
    logic                                in_last;
    logic                                out_valid;
    logic                                out_ready;
    logic [DATA_WIDTH-1:0]               out_data;
    logic                                busy;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/adder_tree_sequencer_adder_array.sv
// Bank of NUM combinational adders; lane gi sums the adjacent operand pair
// (2*gi, 2*gi+1), wrapping modulo 2^DATA_WIDTH.
module adder_array #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM        = 4
) (
    input  logic [2*NUM-1:0][DATA_WIDTH-1:0] i_operands,
    output logic [NUM-1:0][DATA_WIDTH-1:0]   o_sums
);
    generate
        for (genvar gi = 0; gi < NUM; gi++) begin : g_lane
            assign o_sums[gi] = i_operands[2*gi] + i_operands[2*gi+1];
        end
    endgenerate
endmodule

// File: rtl/adder_tree_sequencer.sv
// Folds a 2*NUM-word vector to one sum by reusing a single adder_array over PASSES cycles.
// Optional macro ADDER_TREE_ACC_EN adds a cross-vector accumulator closed by in_last.
module adder_tree_sequencer
    import adder_tree_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM        = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    adder_tree_sequencer_if.slave io_bus
);
    localparam int PASSES = passes_f(NUM);
    localparam int CNT_W  = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam logic [CNT_W-1:0] LAST_PASS = CNT_W'(PASSES - 1);

    state_t                           r_state;
    logic [2*NUM-1:0][DATA_WIDTH-1:0] r_buf;
    logic [CNT_W-1:0]                 r_pass_cnt;
    logic                             r_out_valid;
    logic                             r_busy;

    logic [NUM-1:0][DATA_WIDTH-1:0]   w_sum;
    logic [2*NUM-1:0][DATA_WIDTH-1:0] w_pass_buf;
    logic                             w_in_ready;
    logic                             w_in_fire;
    logic                             w_out_fire;

    adder_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM        (NUM)
    ) u_adders (
        .i_operands (r_buf),
        .o_sums     (w_sum)
    );

    // Each pass packs the lane sums into the low half and zeroes the upper half.
    generate
        for (genvar gi = 0; gi < 2*NUM; gi++) begin : g_pass
            if (gi < NUM) begin : g_keep
                assign w_pass_buf[gi] = w_sum[gi];
            end else begin : g_clear
                assign w_pass_buf[gi] = '0;
            end
        end
    endgenerate

    assign w_in_ready = (r_state == ST_IDLE) || ((r_state == ST_DONE) && io_bus.out_ready);
    assign w_in_fire  = io_bus.in_valid && w_in_ready;
    assign w_out_fire = (r_state == ST_DONE) && io_bus.out_ready;

    assign io_bus.in_ready  = w_in_ready;
    assign io_bus.out_valid = r_out_valid;
    assign io_bus.out_data  = r_buf[0];
    assign io_bus.busy      = r_busy;

`ifdef ADDER_TREE_ACC_EN
    logic [DATA_WIDTH-1:0] r_acc;
    logic                  r_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc  <= '0;
            r_last <= 1'b0;
        end else begin
            if (w_in_fire) begin
                r_last <= io_bus.in_last;
            end
            if (w_out_fire) begin
                r_acc <= '0;
            end else if ((r_state == ST_REDUCE) && (r_pass_cnt == LAST_PASS) && !r_last) begin
                r_acc <= r_acc + w_sum[0];
            end
        end
    end
`else
    logic w_unused_last;
    assign w_unused_last = io_bus.in_last;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_buf       <= '0;
            r_pass_cnt  <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else if (w_in_fire) begin
            // Covers both a load from IDLE and the bubble-free reload from DONE.
            r_buf       <= io_bus.in_data;
            r_pass_cnt  <= '0;
            r_state     <= ST_REDUCE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b1;
        end else begin
            case (r_state)
                ST_REDUCE: begin
                    r_buf      <= w_pass_buf;
                    r_pass_cnt <= r_pass_cnt + 1'b1;
                    if (r_pass_cnt == LAST_PASS) begin
`ifdef ADDER_TREE_ACC_EN
                        if (r_last) begin
                            r_buf[0]    <= w_sum[0] + r_acc;
                            r_state     <= ST_DONE;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
`else
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
`endif
                    end
                end
                ST_DONE: begin
                    if (io_bus.out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_adder_tree_sequencer.sv
// Randomised self-checking bench for adder_tree_sequencer (NUM=4 and NUM=1 instances)
// against a plain-arithmetic reference sum.
module tb_adder_tree_sequencer;
    typedef logic [7:0][31:0] vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    adder_tree_sequencer_if #(.DATA_WIDTH(32), .NUM(4)) bus ();
    adder_tree_sequencer_if #(.DATA_WIDTH(32), .NUM(1)) bus1 ();

    adder_tree_sequencer #(.DATA_WIDTH(32), .NUM(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    adder_tree_sequencer #(.DATA_WIDTH(32), .NUM(1)) dut1 (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus1)
    );

    function automatic logic [31:0] ref_sum(input vec_t v);
        logic [31:0] s;
        s = '0;
        for (int i = 0; i < 8; i++) s = s + v[i];
        return s;
    endfunction

    function automatic vec_t fill_vec(input logic [31:0] val);
        vec_t v;
        for (int i = 0; i < 8; i++) v[i] = val;
        return v;
    endfunction

    function automatic vec_t ramp_vec();
        vec_t v;
        for (int i = 0; i < 8; i++) v[i] = 32'(i + 1);
        return v;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        for (int i = 0; i < 8; i++) v[i] = $urandom;
        return v;
    endfunction

    // Offers one vector, scrambles in_data after the handshake, and waits (bounded)
    // for out_valid; lat counts clock edges after the handshake edge.
    task automatic drive_vec(input vec_t v, input logic last,
                             output logic [31:0] data, output int lat, output bit got);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!bus.in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = v;
        bus.in_last  = last;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = rand_vec();
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        got  = bus.out_valid;
        data = bus.out_data;
        $display("[TB] vector sum=%08h out_valid=%0b out_data=%08h latency=%0d",
                 ref_sum(v), got, data, lat);
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        n_tests++; if (bus.out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data got=%h exp=0", bus.out_data); end
        rst = 1'b0;
        @(negedge clk);
        n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        $display("[TB] reset released");
    endtask

    task automatic test_basic();
        int          busy_cnt;
        int          lat;
        logic [31:0] data;
        busy_cnt = 0;
        lat = -1;
        data = '0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = ramp_vec();
        bus.in_last  = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.out_valid === 1'b1 && lat < 0) begin
                lat  = k;
                data = bus.out_data;
            end
            @(negedge clk);
        end
        bus.out_ready = 1'b0;
        $display("[TB] basic out_data=%0d latency=%0d busy_cycles=%0d", data, lat, busy_cnt);
        n_tests++; if (data !== 32'd36) begin n_fail++; $display("FAIL basic_sum got=%0d exp=36", data); end
        n_tests++; if (lat != 3) begin n_fail++; $display("FAIL basic_latency got=%0d exp=3", lat); end
        n_tests++; if (busy_cnt != 4) begin n_fail++; $display("FAIL basic_busy_cycles got=%0d exp=4", busy_cnt); end
    endtask

    task automatic test_wrap();
        logic [31:0] data;
        int          lat;
        bit          got;
        drive_vec(fill_vec(32'hFFFF_FFFF), 1'b1, data, lat, got);
        n_tests++; if (!got || data !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL wrap_sum got=%h exp=fffffff8", data); end
        consume();
    endtask

    task automatic test_backpressure();
        logic [31:0] data;
        int          lat;
        bit          got;
        int          bad;
        drive_vec(ramp_vec(), 1'b1, data, lat, got);
        n_tests++; if (!got || data !== 32'd36) begin n_fail++; $display("FAIL bp_first_sum got=%0d exp=36", data); end
        bus.in_valid = 1'b1;
        bus.in_data  = fill_vec(32'd1);
        bus.in_last  = 1'b1;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b1 || bus.out_data !== 32'd36 || bus.in_ready !== 1'b0) bad++;
        end
        $display("[TB] backpressure held 10 cycles, unstable_cycles=%0d", bad);
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL bp_hold unstable_cycles=%0d exp=0", bad); end
        bus.out_ready = 1'b1;
        #1;
        n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_in_ready_passthrough got=%b exp=1", bus.in_ready); end
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = rand_vec();
        n_tests++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL bp_reload out_valid=%b busy=%b exp out_valid=0 busy=1", bus.out_valid, bus.busy); end
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        $display("[TB] back-to-back out_data=%0d latency=%0d", bus.out_data, lat);
        n_tests++; if (bus.out_data !== 32'd8 || lat != 3) begin n_fail++; $display("FAIL bp_back_to_back got=%0d lat=%0d exp=8 lat=3", bus.out_data, lat); end
        consume();
    endtask

    task automatic test_reset_mid();
        logic [31:0] data;
        int          lat;
        bit          got;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = ramp_vec();
        bus.in_last  = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_tests++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_async out_valid=%b busy=%b in_ready=%b exp 0/0/1", bus.out_valid, bus.busy, bus.in_ready); end
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        n_tests++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_release out_valid=%b busy=%b in_ready=%b exp 0/0/1", bus.out_valid, bus.busy, bus.in_ready); end
        $display("[TB] reset applied mid-pass");
        drive_vec(fill_vec(32'd2), 1'b1, data, lat, got);
        n_tests++; if (!got || data !== 32'd16 || lat != 3) begin n_fail++; $display("FAIL midreset_next got=%0d lat=%0d exp=16 lat=3", data, lat); end
        consume();
    endtask

    task automatic test_random();
        vec_t        v;
        logic [31:0] data;
        int          lat;
        bit          got;
        for (int t = 0; t < 20; t++) begin
            v = rand_vec();
            drive_vec(v, 1'b1, data, lat, got);
            n_tests++; if (!got || data !== ref_sum(v) || lat != 3) begin n_fail++; $display("FAIL random_%0d got=%h lat=%0d exp=%h lat=3", t, data, lat, ref_sum(v)); end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            consume();
        end
    endtask

    task automatic test_num1();
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        for (int t = 0; t < 4; t++) begin
            a = (t == 0) ? 32'd5 : $urandom;
            b = (t == 0) ? -32'sd3 : $urandom;
            @(negedge clk);
            bus1.in_valid   = 1'b1;
            bus1.in_data[0] = a;
            bus1.in_data[1] = b;
            bus1.in_last    = 1'b1;
            @(negedge clk);
            bus1.in_valid = 1'b0;
            bus1.in_data  = {$urandom, $urandom};
            lat = 0;
            while (!bus1.out_valid && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            $display("[TB] num1 a=%h b=%h out_data=%h latency=%0d", a, b, bus1.out_data, lat);
            n_tests++; if (bus1.out_data !== a + b || lat != 1) begin n_fail++; $display("FAIL num1_%0d got=%h lat=%0d exp=%h lat=1", t, bus1.out_data, lat, a + b); end
            bus1.out_ready = 1'b1;
            @(negedge clk);
            bus1.out_ready = 1'b0;
        end
    endtask

`ifdef ADDER_TREE_ACC_EN
    task automatic test_acc();
        logic [31:0] data;
        int          lat;
        bit          got;
        int          seen;
        for (int g = 1; g <= 2; g++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = fill_vec(32'(g));
            bus.in_last  = 1'b0;
            @(negedge clk);
            bus.in_valid = 1'b0;
            seen = 0;
            for (int k = 0; k < 8; k++) begin
                if (bus.out_valid === 1'b1) seen++;
                @(negedge clk);
            end
            $display("[TB] acc partial vector of %0ds, out_valid cycles=%0d", g, seen);
            n_tests++; if (seen != 0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL acc_partial_%0d out_valid_cycles=%0d busy=%b exp 0/0", g, seen, bus.busy); end
        end
        drive_vec(fill_vec(32'd3), 1'b1, data, lat, got);
        n_tests++; if (!got || data !== 32'd48) begin n_fail++; $display("FAIL acc_group got=%0d exp=48", data); end
        consume();
        drive_vec(fill_vec(32'd1), 1'b1, data, lat, got);
        n_tests++; if (!got || data !== 32'd8) begin n_fail++; $display("FAIL acc_cleared got=%0d exp=8", data); end
        consume();
    endtask
`endif

    initial begin
        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.in_last    = 1'b0;
        bus.out_ready  = 1'b0;
        bus1.in_valid  = 1'b0;
        bus1.in_data   = '0;
        bus1.in_last   = 1'b0;
        bus1.out_ready = 1'b0;

        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_reset_mid();
        test_random();
        test_num1();
`ifdef ADDER_TREE_ACC_EN
        test_acc();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
